// File: rtl/datapath_param.sv
// rtl/datapath_param.sv - parametrised Simple-CPU datapath with flags register and fetch FSM
module datapath_param #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int IADDR_W = 8,
  parameter int NREGS   = 8,
  parameter int IMM_W   = 16,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               fetch_start,
  output logic               imem_req,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               fetch_busy,
  output logic               ir_valid,
  input  logic               pc_write_enable,
  input  logic [1:0]         pc_source_sel,
  input  logic               rf_write_enable,
  input  logic [REG_AW-1:0]  rf_write_addr,
  input  logic [1:0]         rf_write_data_sel,
  input  logic [2:0]         alu_op_sel,
  input  logic               alu_b_src_sel,
  input  logic               imm_sext,
  input  logic               flags_write_enable,
  output logic [3:0]         opcode_out,
  output logic [REG_AW-1:0]  rd_out,
  output logic [REG_AW-1:0]  rs_out,
  output logic [3:0]         flags_out,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [31:0]        ir_debug_out
);

  localparam int MSB = DATA_W - 1;

  generate
    if ((4 + 2*REG_AW + IMM_W > 32) || (DATA_W < 8) || (IADDR_W > PC_W) ||
        (NREGS < 4) || ((NREGS & (NREGS - 1)) != 0)) begin : g_param_check
      $error("datapath_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [0:0] {F_IDLE, F_REQ} fstate_t;

  fstate_t             state, state_nx;
  logic                ir_load;
  logic [31:0]         ir;
  logic [PC_W-1:0]     pc, pc_nx, pc_inc, imm_pc, lr_pc;
  logic [DATA_W-1:0]   rf [NREGS];
  logic [REG_AW-1:0]   port_a_idx;
  logic [DATA_W-1:0]   port_a, port_b, alu_b, alu_res, rf_wdata;
  logic [DATA_W-1:0]   imm_data, imm_data_s, imm_data_z, pc_inc_data, flags_data;
  logic [DATA_W:0]     sum;
  logic [IMM_W-1:0]    imm;
  logic                alu_c, alu_v;
  logic [3:0]          flags;

  // Fetch FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= F_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      F_IDLE:  if (fetch_start) state_nx = F_REQ;
      F_REQ:   if (imem_ack)    state_nx = F_IDLE;
      default: state_nx = F_IDLE;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    fetch_busy = 1'b0;
    ir_load    = 1'b0;
    if (state == F_REQ) begin
      imem_req   = 1'b1;
      fetch_busy = 1'b1;
      ir_load    = imem_ack;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= ir_load;
      if (ir_load) ir <= imem_rdata;
    end
  end

  assign opcode_out   = ir[31:28];
  assign rd_out       = ir[27 -: REG_AW];
  assign rs_out       = ir[27-REG_AW -: REG_AW];
  assign imm          = ir[IMM_W-1:0];
  assign ir_debug_out = ir;

  assign imm_data_s  = DATA_W'($signed(imm));
  assign imm_data_z  = DATA_W'(imm);
  assign imm_data    = imm_sext ? imm_data_s : imm_data_z;
  // Branch offsets are always signed, independent of imm_sext
  assign imm_pc      = PC_W'($signed(imm));

  // Program counter
  assign pc_inc      = pc + PC_W'(1);
  assign lr_pc       = PC_W'(port_a);
  assign pc_inc_data = DATA_W'(pc_inc);
  assign imem_addr   = pc[IADDR_W-1:0];

  always_comb begin
    pc_nx = pc_inc;
    case (pc_source_sel)
      2'b00: pc_nx = pc_inc;
      2'b01: pc_nx = pc + imm_pc;
      2'b10: pc_nx = lr_pc;
      2'b11: pc_nx = pc + imm_pc;
      default: pc_nx = pc_inc;
    endcase
  end

  // PC is frozen during a fetch so imem_addr stays stable while imem_req is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             pc <= '0;
    else if (pc_write_enable && !fetch_busy)  pc <= pc_nx;
  end

  // Register file
  assign port_a_idx = (pc_source_sel == 2'b10) ? REG_AW'(NREGS - 1) : rd_out;
  assign port_a     = rf[port_a_idx];
  assign port_b     = rf[rs_out];
  assign dbg_data   = rf[dbg_sel];
  assign flags_data = DATA_W'(flags);

  always_comb begin
    rf_wdata = alu_res;
    case (rf_write_data_sel)
      2'b00: rf_wdata = alu_res;
      2'b01: rf_wdata = imm_data;
      2'b10: rf_wdata = pc_inc_data;
      2'b11: rf_wdata = flags_data;
      default: rf_wdata = alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (rf_write_enable) begin
      rf[rf_write_addr] <= rf_wdata;
    end
  end

  // ALU
  assign alu_b = alu_b_src_sel ? imm_data : port_b;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_sel)
      3'b000: begin
        sum     = {1'b0, port_a} + {1'b0, alu_b};
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (port_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != port_a[MSB]);
      end
      3'b001: begin
        sum     = {1'b0, port_a} + {1'b0, ~alu_b} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (port_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != port_a[MSB]);
      end
      3'b010: alu_res = port_a & alu_b;
      3'b011: alu_res = port_a | alu_b;
      3'b100: alu_res = port_a ^ alu_b;
      3'b101: alu_res = alu_b;
      3'b110: begin
        alu_res = {port_a[MSB-1:0], 1'b0};
        alu_c   = port_a[MSB];
      end
      3'b111: begin
        alu_res = {1'b0, port_a[MSB:1]};
        alu_c   = port_a[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Flags {V,C,N,Z}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                flags <= '0;
    else if (flags_write_enable) flags <= {alu_v, alu_c, alu_res[MSB], (alu_res == '0)};
  end

  assign flags_out = flags;

endmodule

// File: tb/tb_datapath_param.sv
// tb/tb_datapath_param.sv - scoreboard bench for datapath_param (default and 32-bit/16-reg builds)
module tb_datapath_param;

  localparam int P_REQ = 0, P_BUSY = 1, P_IRV = 2, P_IR = 3, P_OP = 4, P_RD = 5, P_RS = 6;
  localparam int P_FLAGS = 7, P_DBG = 8, P_ADDR = 9, P_FLAGS32 = 10, P_DBG32 = 11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_start, imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_we, rf_we, rf_we32, flags_we, flags_we32, b_src, imm_sext;
  logic [1:0]  pc_sel, wsel;
  logic [2:0]  alu_op;
  logic [2:0]  rf_waddr, dbg_sel, rd_o, rs_o;
  logic [3:0]  rf_waddr32, dbg_sel32, rd_o32, rs_o32;
  logic        imem_req, fetch_busy, ir_valid, imem_req32, fetch_busy32, ir_valid32;
  logic [7:0]  imem_addr, imem_addr32;
  logic [3:0]  opcode_o, opcode_o32, flags_o, flags_o32;
  logic [15:0] dbg_data;
  logic [31:0] dbg_data32, ir_dbg, ir_dbg32;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;
  logic prev_irv = 1'b0;
  logic final_chk = 1'b0;
  logic mon_done = 1'b0;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] val_q[$];
  logic [31:0] irw_q[$];
  int          irr_q[$];

  always #5 clk = ~clk;

  datapath_param u_dut (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_busy(fetch_busy),
    .ir_valid(ir_valid), .pc_write_enable(pc_we), .pc_source_sel(pc_sel),
    .rf_write_enable(rf_we), .rf_write_addr(rf_waddr), .rf_write_data_sel(wsel),
    .alu_op_sel(alu_op), .alu_b_src_sel(b_src), .imm_sext(imm_sext),
    .flags_write_enable(flags_we), .opcode_out(opcode_o), .rd_out(rd_o), .rs_out(rs_o),
    .flags_out(flags_o), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .ir_debug_out(ir_dbg)
  );

  datapath_param #(.DATA_W(32), .NREGS(16)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .imem_req(imem_req32),
    .imem_addr(imem_addr32), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .fetch_busy(fetch_busy32),
    .ir_valid(ir_valid32), .pc_write_enable(pc_we), .pc_source_sel(pc_sel),
    .rf_write_enable(rf_we32), .rf_write_addr(rf_waddr32), .rf_write_data_sel(wsel),
    .alu_op_sel(alu_op), .alu_b_src_sel(b_src), .imm_sext(imm_sext),
    .flags_write_enable(flags_we32), .opcode_out(opcode_o32), .rd_out(rd_o32), .rs_out(rs_o32),
    .flags_out(flags_o32), .dbg_sel(dbg_sel32), .dbg_data(dbg_data32), .ir_debug_out(ir_dbg32)
  );

  function automatic logic [31:0] probe(input int s);
    case (s)
      P_REQ:     return {31'b0, imem_req};
      P_BUSY:    return {31'b0, fetch_busy};
      P_IRV:     return {31'b0, ir_valid};
      P_IR:      return ir_dbg;
      P_OP:      return {28'b0, opcode_o};
      P_RD:      return {29'b0, rd_o};
      P_RS:      return {29'b0, rs_o};
      P_FLAGS:   return {28'b0, flags_o};
      P_DBG:     return {16'b0, dbg_data};
      P_ADDR:    return {24'b0, imem_addr};
      P_FLAGS32: return {28'b0, flags_o32};
      P_DBG32:   return dbg_data32;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 6'b0, imm};
  endfunction

  function automatic logic [31:0] mk32(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 4'b0, imm};
  endfunction

  // Monitor: fetch responses on ir_valid, queued observations on every falling edge
  always @(negedge clk) begin
    if (!reset_n) req_cnt = 0;
    else if (imem_req) req_cnt++;
    if (ir_valid) begin
      if (irw_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ir_valid_unexpected: got ir=0x%08h, required no ir_valid", ir_dbg);
      end else begin
        logic [31:0] w;
        int r;
        w = irw_q.pop_front();
        r = irr_q.pop_front();
        checks++;
        if (ir_dbg !== w) begin
          errors++; $display("FAIL fetch_ir: got 0x%08h, required 0x%08h", ir_dbg, w);
        end
        checks++;
        if (req_cnt != r) begin
          errors++; $display("FAIL fetch_req_cycles: got %0d, required %0d", req_cnt, r);
        end
        checks++;
        if (prev_irv !== 1'b0) begin
          errors++; $display("FAIL ir_valid_pulse: got 2+ cycles, required 1 cycle");
        end
      end
      req_cnt = 0;
    end
    prev_irv = ir_valid;
    while (name_q.size() > 0) begin
      string n;
      int s;
      logic [31:0] v, a;
      n = name_q.pop_front();
      s = sel_q.pop_front();
      v = val_q.pop_front();
      a = probe(s);
      checks++;
      if (a !== v) begin
        errors++; $display("FAIL %s: got 0x%0h, required 0x%0h", n, a, v);
      end
    end
    if (final_chk && !mon_done) begin
      checks++;
      if (irw_q.size() != 0) begin
        errors++; $display("FAIL fetch_outstanding: got %0d pending, required 0", irw_q.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int s, input logic [31:0] v);
    name_q.push_back(n);
    sel_q.push_back(s);
    val_q.push_back(v);
  endtask

  task automatic fetch(input logic [31:0] w, input int dly, input logic hold_pc);
    irw_q.push_back(w);
    irr_q.push_back(dly + 1);
    fetch_start = 1'b1;
    step();
    if (hold_pc) begin
      pc_we  = 1'b1;
      pc_sel = 2'b00;
    end
    repeat (dly) step();
    fetch_start = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = w;
    step();
    imem_ack    = 1'b0;
    pc_we       = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic do_op(input logic [2:0] op, input logic bsrc, input logic sx, input logic fwe,
                       input logic [3:0] wa, input logic [1:0] ws, input logic t32);
    alu_op   = op;
    b_src    = bsrc;
    imm_sext = sx;
    wsel     = ws;
    pc_sel   = 2'b00;
    if (t32) begin
      rf_we32 = 1'b1; rf_waddr32 = wa; flags_we32 = fwe;
    end else begin
      rf_we = 1'b1; rf_waddr = wa[2:0]; flags_we = fwe;
    end
    step();
    rf_we = 1'b0; rf_we32 = 1'b0; flags_we = 1'b0; flags_we32 = 1'b0;
  endtask

  task automatic load_reg(input logic [2:0] r, input logic [15:0] v);
    fetch(mk(4'h0, 3'd0, 3'd0, v), 0, 1'b0);
    do_op(3'b000, 1'b0, 1'b0, 1'b0, {1'b0, r}, 2'b01, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; fetch_start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    pc_we = 1'b0; pc_sel = 2'b00; rf_we = 1'b0; rf_we32 = 1'b0; rf_waddr = 3'd0; rf_waddr32 = 4'd0;
    wsel = 2'b00; alu_op = 3'b000; b_src = 1'b0; imm_sext = 1'b0; flags_we = 1'b0;
    flags_we32 = 1'b0; dbg_sel = 3'd0; dbg_sel32 = 4'd0;
    step(); step();

    dbg_sel = 3'd7;
    chk("rst_req", P_REQ, 0); chk("rst_busy", P_BUSY, 0); chk("rst_irv", P_IRV, 0);
    chk("rst_ir", P_IR, 0); chk("rst_flags", P_FLAGS, 0); chk("rst_addr", P_ADDR, 0);
    chk("rst_r7", P_DBG, 0);
    step();
    reset_n = 1'b1;
    step();

    // Slow fetch with PC writes attempted while busy
    fetch(32'h1234_5678, 3, 1'b1);
    chk("fetch_opcode", P_OP, 1); chk("fetch_rd", P_RD, 1); chk("fetch_rs", P_RS, 0);
    chk("fetch_pc_frozen", P_ADDR, 0); chk("fetch_busy_done", P_BUSY, 0);
    step();

    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    step();
    imem_ack = 1'b0;
    chk("idle_ack_ir", P_IR, 32'h1234_5678); chk("idle_ack_irv", P_IRV, 0);
    step();

    // Reset in the middle of a fetch
    pc_we = 1'b1; pc_sel = 2'b00;
    step(); step();
    pc_we = 1'b0;
    chk("pc_two", P_ADDR, 2);
    step();
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("midfetch_req", P_REQ, 1); chk("midfetch_busy", P_BUSY, 1); chk("midfetch_addr", P_ADDR, 2);
    step();
    #1;
    reset_n = 1'b0;
    chk("abort_req", P_REQ, 0); chk("abort_busy", P_BUSY, 0);
    chk("abort_ir", P_IR, 0); chk("abort_pc", P_ADDR, 0);
    step();
    reset_n = 1'b1;
    step();

    // PC arithmetic and wrap
    pc_we = 1'b1; pc_sel = 2'b00;
    step(); step();
    pc_we = 1'b0;
    fetch(mk(4'h0, 3'd0, 3'd0, 16'hFFFC), 0, 1'b0);
    pc_we = 1'b1; pc_sel = 2'b01; imm_sext = 1'b0;
    step();
    pc_we = 1'b0;
    chk("pc_rel_addr", P_ADDR, 8'hFE);
    rf_we = 1'b1; rf_waddr = 3'd1; wsel = 2'b10;
    step();
    rf_we = 1'b0; dbg_sel = 3'd1;
    chk("pc_rel_full", P_DBG, 16'hFFFF);
    pc_we = 1'b1; pc_sel = 2'b00;
    step();
    chk("pc_inc_ff", P_ADDR, 8'hFF);
    step();
    pc_we = 1'b0;
    chk("pc_wrap", P_ADDR, 0);
    rf_we = 1'b1; rf_waddr = 3'd2; wsel = 2'b10;
    step();
    rf_we = 1'b0; dbg_sel = 3'd2;
    chk("pc_wrap_full", P_DBG, 16'h0001);
    step();

    // Call and return through the link register
    fetch(mk(4'h0, 3'd0, 3'd0, 16'h0010), 0, 1'b0);
    pc_we = 1'b1; pc_sel = 2'b01;
    step();
    pc_we = 1'b0;
    fetch(mk(4'h0, 3'd0, 3'd0, 16'h0020), 0, 1'b0);
    pc_we = 1'b1; pc_sel = 2'b11; rf_we = 1'b1; rf_waddr = 3'd7; wsel = 2'b10;
    step();
    pc_we = 1'b0; rf_we = 1'b0; dbg_sel = 3'd7;
    chk("call_pc", P_ADDR, 8'h30); chk("call_lr", P_DBG, 16'h0011);
    pc_we = 1'b1; pc_sel = 2'b10;
    step();
    pc_we = 1'b0; pc_sel = 2'b00;
    chk("ret_pc", P_ADDR, 8'h11);
    rf_we = 1'b1; rf_waddr = 3'd6; wsel = 2'b10;
    step();
    rf_we = 1'b0; dbg_sel = 3'd6;
    chk("ret_pc_full", P_DBG, 16'h0012);
    step();

    // ALU and flags
    load_reg(3'd1, 16'h7FFF);
    load_reg(3'd2, 16'h0001);
    fetch(mk(4'h5, 3'd1, 3'd2, 16'h0000), 0, 1'b0);
    chk("dec_opcode", P_OP, 5); chk("dec_rd", P_RD, 1); chk("dec_rs", P_RS, 2);
    do_op(3'b000, 1'b0, 1'b0, 1'b1, 4'd3, 2'b00, 1'b0);
    dbg_sel = 3'd3;
    chk("add_flags", P_FLAGS, 4'hA); chk("add_res", P_DBG, 16'h8000);
    step();
    do_op(3'b010, 1'b0, 1'b0, 1'b0, 4'd4, 2'b00, 1'b0);
    dbg_sel = 3'd4;
    chk("and_flags_held", P_FLAGS, 4'hA); chk("and_res", P_DBG, 16'h0001);
    step();
    do_op(3'b100, 1'b0, 1'b0, 1'b0, 4'd6, 2'b00, 1'b0);
    dbg_sel = 3'd6;
    chk("xor_res", P_DBG, 16'h7FFE);
    step();
    do_op(3'b011, 1'b0, 1'b0, 1'b0, 4'd6, 2'b00, 1'b0);
    chk("or_res", P_DBG, 16'h7FFF);
    step();
    fetch(mk(4'h0, 3'd1, 3'd1, 16'h0000), 0, 1'b0);
    do_op(3'b001, 1'b0, 1'b0, 1'b1, 4'd5, 2'b11, 1'b0);
    dbg_sel = 3'd5;
    chk("sub_zero_flags", P_FLAGS, 4'h5); chk("flags_write_old", P_DBG, 16'h000A);
    step();
    fetch(mk(4'h0, 3'd1, 3'd0, 16'h0000), 0, 1'b0);
    do_op(3'b111, 1'b0, 1'b0, 1'b1, 4'd6, 2'b00, 1'b0);
    dbg_sel = 3'd6;
    chk("shr_flags", P_FLAGS, 4'h4); chk("shr_res", P_DBG, 16'h3FFF);
    step();
    fetch(mk(4'h0, 3'd3, 3'd0, 16'h0000), 0, 1'b0);
    do_op(3'b110, 1'b0, 1'b0, 1'b1, 4'd6, 2'b00, 1'b0);
    chk("shl_flags", P_FLAGS, 4'h5); chk("shl_res", P_DBG, 16'h0000);
    step();
    fetch(mk(4'h0, 3'd1, 3'd2, 16'hFFFC), 0, 1'b0);
    do_op(3'b101, 1'b1, 1'b1, 1'b1, 4'd4, 2'b00, 1'b0);
    dbg_sel = 3'd4;
    chk("passb_flags", P_FLAGS, 4'h2); chk("passb_res", P_DBG, 16'hFFFC);
    step();

    // 32-bit data, 16 registers
    fetch(mk32(4'h0, 4'd0, 4'd0, 16'h0001), 0, 1'b0);
    do_op(3'b000, 1'b0, 1'b0, 1'b0, 4'd1, 2'b01, 1'b1);
    fetch(mk32(4'h0, 4'd0, 4'd1, 16'h0000), 0, 1'b0);
    do_op(3'b001, 1'b0, 1'b0, 1'b1, 4'd15, 2'b00, 1'b1);
    dbg_sel32 = 4'd15;
    chk("w32_sub_flags", P_FLAGS32, 4'h2); chk("w32_r15", P_DBG32, 32'hFFFF_FFFF);
    step();
    fetch(mk32(4'h0, 4'd0, 4'd0, 16'hFFFF), 0, 1'b0);
    do_op(3'b000, 1'b0, 1'b1, 1'b0, 4'd14, 2'b01, 1'b1);
    do_op(3'b000, 1'b0, 1'b0, 1'b0, 4'd13, 2'b01, 1'b1);
    dbg_sel32 = 4'd14;
    chk("w32_imm_sext", P_DBG32, 32'hFFFF_FFFF);
    step();
    dbg_sel32 = 4'd13;
    chk("w32_imm_zext", P_DBG32, 32'h0000_FFFF);
    step();

    repeat (3) step();
    final_chk = 1'b1;
    for (int i = 0; i < 20 && !mon_done; i++) step();
    if (!mon_done) begin
      $display("FAIL monitor_done: got no final check, required completion within 20 cycles");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
